// File: rtl/mdu_pkg.sv
// mdu_pkg: op and state encodings shared by the iterative multiply/divide unit.
package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

endpackage

// File: rtl/mdu_negate.sv
// mdu_negate: conditional two's-complement negate.
module mdu_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? -val_i : val_i;

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: iterative MULT/MULTU/DIV/DIVU into HI/LO, one bit per cycle.
// Optional MDU_EARLY_OUT_EN ends multiply CALC once the remaining multiplier bits are zero.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter  int N     = 32,
    localparam int CNT_W = $clog2(N) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic [N-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         div_by_zero
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*N-1:0]     acc_q, acc_d;
    logic [N-1:0]       sr_q, sr_d, opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
    logic               div_q, div_d, sa_q, sa_d, sb_q, sb_d, dbz_q, dbz_d;

    logic               is_div, sgn, idle, go, last, qbit, dz;
    logic [N-1:0]       abs_a, abs_b, q_f, r_f, res_hi, res_lo;
    logic [N:0]         msum, rsh, rsub;
    logic [2*N-1:0]     mul_nxt, div_nxt, prod_al, prod_f;

    assign is_div = (op == OP_DIV) || (op == OP_DIVU);
    assign sgn    = (op == OP_MULT) || (op == OP_DIV);
    assign idle   = (state_q == S_IDLE) || (state_q == S_DONE);
    assign go     = start && idle;
    assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
    assign done   = state_q == S_DONE;

    mdu_negate #(.W(N)) u_abs_a (.val_i(a), .neg_i(sgn && a[N-1]), .val_o(abs_a));
    mdu_negate #(.W(N)) u_abs_b (.val_i(b), .neg_i(sgn && b[N-1]), .val_o(abs_b));

    // Shift-add: upper half accumulates, the whole register shifts right each step.
    assign msum    = {1'b0, acc_q[2*N-1:N]} + {1'b0, sr_q[0] ? opnd_q : {N{1'b0}}};
    assign mul_nxt = {msum, acc_q[N-1:1]};

    // Restoring divide: upper half is the partial remainder, lower half dividend/quotient.
    assign rsh     = acc_q[2*N-1:N-1];
    assign rsub    = rsh - {1'b0, opnd_q};
    assign qbit    = rsh >= {1'b0, opnd_q};
    assign div_nxt = {qbit ? rsub[N-1:0] : rsh[N-1:0], acc_q[N-2:0], qbit};

`ifdef MDU_EARLY_OUT_EN
    assign last    = div_q ? (cnt_q == CNT_W'(N - 1)) : (sr_q[N-1:1] == '0);
    assign prod_al = acc_q >> (CNT_W'(N) - cnt_q);
`else
    assign last    = cnt_q == CNT_W'(N - 1);
    assign prod_al = acc_q;
`endif

    mdu_negate #(.W(2*N)) u_fix_p (.val_i(prod_al), .neg_i(sa_q ^ sb_q), .val_o(prod_f));
    mdu_negate #(.W(N))   u_fix_q (.val_i(acc_q[N-1:0]), .neg_i(sa_q ^ sb_q), .val_o(q_f));
    mdu_negate #(.W(N))   u_fix_r (.val_i(acc_q[2*N-1:N]), .neg_i(sa_q), .val_o(r_f));

    // A zero divisor leaves |a| in the remainder, so the remainder fix restores a itself.
    assign dz     = div_q && (opnd_q == '0);
    assign res_hi = div_q ? r_f : prod_f[2*N-1:N];
    assign res_lo = div_q ? (dz ? {N{1'b1}} : q_f) : prod_f[N-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sr_d    = sr_q;
        opnd_d  = opnd_q;
        div_d   = div_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dbz_d   = dbz_q;
        hi_d    = (!busy && hi_we) ? wdata : hi_q;
        lo_d    = (!busy && lo_we) ? wdata : lo_q;
        if (go) begin
            state_d = S_CALC;
            cnt_d   = '0;
            div_d   = is_div;
            sa_d    = sgn && a[N-1];
            sb_d    = sgn && b[N-1];
            opnd_d  = is_div ? abs_b : abs_a;
            sr_d    = abs_b;
            acc_d   = is_div ? {{N{1'b0}}, abs_a} : '0;
            dbz_d   = 1'b0;
        end else if (state_q == S_CALC) begin
            state_d = last ? S_FIX : S_CALC;
            cnt_d   = cnt_q + 1'b1;
            acc_d   = div_q ? div_nxt : mul_nxt;
            sr_d    = sr_q >> 1;
        end else if (state_q == S_FIX) begin
            state_d = S_DONE;
            hi_d    = res_hi;
            lo_d    = res_lo;
            dbz_d   = dz;
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            sr_q    <= '0;
            opnd_q  <= '0;
            div_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sr_q    <= sr_d;
            opnd_q  <= opnd_d;
            div_q   <= div_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dbz_q   <= dbz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: scoreboard bench for mdu_seq; expected results queued at issue, checked on done.
module tb_mdu_seq;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst, start, hi_we, lo_we;
    logic [1:0]   op;
    logic [N-1:0] a, b, wdata;
    logic         busy, done, div_by_zero;
    logic [N-1:0] hi, lo;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [N-1:0] hi;
        logic [N-1:0] lo;
        logic         dz;
        int           scyc;
        int           lat;
    } exp_t;

    exp_t sb[$];

    mdu_seq #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic int lat_of(input logic [1:0] o, input logic [N-1:0] bb);
        int k;
        logic [N-1:0] m;
        lat_of = N + 1;
`ifdef MDU_EARLY_OUT_EN
        if (!o[1]) begin
            m = (o == 2'b00 && bb[N-1]) ? -bb : bb;
            k = 1;
            for (int i = 0; i < N; i++) if (m[i]) k = i + 1;
            lat_of = k + 1;
        end
`endif
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 expected=0");
            end else begin
                e = sb.pop_front();
                chk("hi", 64'(hi), 64'(e.hi));
                chk("lo", 64'(lo), 64'(e.lo));
                chk("div_by_zero", 64'(div_by_zero), 64'(e.dz));
                chk("latency", 64'(cyc - e.scyc), 64'(e.lat));
            end
        end
    end

    // Call at a negedge; returns just after the start edge with junk on the operand inputs.
    task automatic issue(input logic [1:0] o, input logic [N-1:0] aa, input logic [N-1:0] bb,
                         input logic [N-1:0] eh, input logic [N-1:0] el, input logic ed);
        exp_t e;
        start = 1'b1; op = o; a = aa; b = bb;
        @(posedge clk);
        #1;
        start = 1'b0; op = ~o; a = 32'h1234_5678; b = 32'h0000_0009;
        e.hi = eh; e.lo = el; e.dz = ed; e.scyc = cyc; e.lat = lat_of(o, bb);
        sb.push_back(e);
    endtask

    task automatic wait_done(output int bc);
        bc = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (busy) bc++;
            if (sb.size() == 0 && !busy) break;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=pending expected=none");
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        int dcnt;
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        rst = 1'b0;

        // mthi / mtlo in IDLE
        hi_we = 1'b1; wdata = 32'hAAAA_5555;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h0F0F_0F0F;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mthi_idle", 64'(hi), 64'hAAAA_5555);
        chk("mtlo_idle", 64'(lo), 64'h0F0F_0F0F);

        // MULTU max*max, with mthi and a competing start while busy
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        chk("busy_after_start", 64'(busy), 64'd1);
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
        @(negedge clk);
        hi_we = 1'b0; start = 1'b0;
        chk("mthi_busy_ignored", 64'(hi), 64'hAAAA_5555);
        wait_done(bc);

        @(negedge clk);
        issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        wait_done(bc);
        chk("busy_cycles_mult", 64'(bc), 64'(lat_of(2'b00, 32'h5)));

        @(negedge clk);
        issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        wait_done(bc);
        @(negedge clk);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        wait_done(bc);
        @(negedge clk);
        issue(2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1);
        wait_done(bc);
        repeat (3) @(negedge clk);
        chk("dbz_held", 64'(div_by_zero), 64'd1);
        issue(2'b01, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, 1'b0);
        chk("dbz_cleared_on_start", 64'(div_by_zero), 64'd0);
        wait_done(bc);

        @(negedge clk);
        issue(2'b10, 32'hFFFF_FFF7, 32'h0000_0000, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1);
        wait_done(bc);
        @(negedge clk);
        issue(2'b00, 32'h0000_1234, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
        wait_done(bc);
        @(negedge clk);
        issue(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
        wait_done(bc);
        @(negedge clk);
        issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        wait_done(bc);

        // Back-to-back: start during DONE, with mthi on the accepting edge
        @(negedge clk);
        issue(2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done) break;
        end
        hi_we = 1'b1; wdata = 32'hCAFE_F00D;
        issue(2'b10, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b0);
        hi_we = 1'b0;
        chk("mthi_with_start", 64'(hi), 64'hCAFE_F00D);
        wait_done(bc);

        // Reset at edge 10 of an operation
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'h0000_0011; b = 32'h0000_0022;
        repeat (10) @(posedge clk);
        #1;
        start = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midop_rst_busy", 64'(busy), 64'd0);
        chk("midop_rst_hi", 64'(hi), 64'd0);
        chk("midop_rst_lo", 64'(lo), 64'd0);
        dcnt = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("midop_rst_no_done", 64'(dcnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
